// File: rtl/regfile_dump_fill.sv
// Purpose : maintenance sequencer for the register file; fills a register range with one
//           value through the write port, or dumps a range through the debug read port.
// Latency : fill = one write per cycle starting the cycle after start; dump = first beat
//           two edges after start, then one beat per two cycles; done pulses for one cycle.
// Backpr. : dump beats use dumpValid/dumpReady; a beat and its data are held while dumpReady
//           is low. Fill mode has no backpressure.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   start, mode              command strobe (IDLE only), 0 = dump / 1 = fill
//   firstReg, lastReg        inclusive register range, latched with start
//   fillValue                fill data, latched with start
//   outvalue / inr           register file debug read data / read index
//   writeReg, writeData,
//   controlRegWrite          register file write port
//   dumpData, dumpIndex,
//   dumpValid, dumpReady     dump beat stream
//   busy, done               status: busy outside IDLE, done one-cycle completion pulse
module regfile_dump_fill #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] firstReg,
    input  logic [ADDR_WIDTH-1:0] lastReg,
    input  logic [DATA_WIDTH-1:0] fillValue,
    input  logic [DATA_WIDTH-1:0] outvalue,
    output logic [ADDR_WIDTH-1:0] inr,
    output logic [ADDR_WIDTH-1:0] writeReg,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  controlRegWrite,
    output logic [DATA_WIDTH-1:0] dumpData,
    output logic [ADDR_WIDTH-1:0] dumpIndex,
    output logic                  dumpValid,
    input  logic                  dumpReady,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SETUP,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [DATA_WIDTH-1:0] r_fill_value;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_cur_nxt;
    logic [ADDR_WIDTH-1:0] w_last_nxt;
    logic [DATA_WIDTH-1:0] w_fill_value_nxt;
    logic [ADDR_WIDTH-1:0] w_inr_nxt;
    logic [ADDR_WIDTH-1:0] w_write_reg_nxt;
    logic [DATA_WIDTH-1:0] w_write_data_nxt;
    logic                  w_write_en_nxt;
    logic [DATA_WIDTH-1:0] w_dump_data_nxt;
    logic [ADDR_WIDTH-1:0] w_dump_index_nxt;
    logic                  w_dump_valid_nxt;
    logic                  w_done_nxt;
    logic                  w_busy_nxt;
    logic [ADDR_WIDTH-1:0] w_cur_inc;
    logic                  w_at_last;

    assign w_cur_inc = r_cur + ADDR_ONE;
    // Termination is by equality, so the increment never has to wrap past the last index.
    assign w_at_last = (r_cur == r_last);

    always_comb begin
        w_state_nxt      = r_state;
        w_cur_nxt        = r_cur;
        w_last_nxt       = r_last;
        w_fill_value_nxt = r_fill_value;
        w_inr_nxt        = inr;
        w_write_reg_nxt  = writeReg;
        w_write_data_nxt = writeData;
        w_write_en_nxt   = controlRegWrite;
        w_dump_data_nxt  = dumpData;
        w_dump_index_nxt = dumpIndex;
        w_dump_valid_nxt = dumpValid;
        w_done_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cur_nxt        = firstReg;
                    w_last_nxt       = lastReg;
                    w_fill_value_nxt = fillValue;
                    if (firstReg > lastReg) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else if (mode) begin
                        w_state_nxt      = S_FILL;
                        w_write_en_nxt   = 1'b1;
                        w_write_reg_nxt  = firstReg;
                        w_write_data_nxt = fillValue;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_inr_nxt   = firstReg;
                    end
                end
            end
            S_FILL: begin
                if (w_at_last) begin
                    w_write_en_nxt = 1'b0;
                    w_state_nxt    = S_DONE;
                    w_done_nxt     = 1'b1;
                end else begin
                    w_cur_nxt        = w_cur_inc;
                    w_write_reg_nxt  = w_cur_inc;
                    w_write_data_nxt = r_fill_value;
                end
            end
            S_SETUP: begin
                // inr has been stable for a full cycle, so outvalue is settled here.
                w_dump_data_nxt  = outvalue;
                w_dump_index_nxt = r_cur;
                w_dump_valid_nxt = 1'b1;
                w_state_nxt      = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (dumpReady) begin
                    w_dump_valid_nxt = 1'b0;
                    if (w_at_last) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cur_nxt   = w_cur_inc;
                        w_inr_nxt   = w_cur_inc;
                        w_state_nxt = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // busy is registered, so it reflects the state being entered.
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cur           <= '0;
            r_last          <= '0;
            r_fill_value    <= '0;
            inr             <= '0;
            writeReg        <= '0;
            writeData       <= '0;
            controlRegWrite <= 1'b0;
            dumpData        <= '0;
            dumpIndex       <= '0;
            dumpValid       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cur           <= w_cur_nxt;
            r_last          <= w_last_nxt;
            r_fill_value    <= w_fill_value_nxt;
            inr             <= w_inr_nxt;
            writeReg        <= w_write_reg_nxt;
            writeData       <= w_write_data_nxt;
            controlRegWrite <= w_write_en_nxt;
            dumpData        <= w_dump_data_nxt;
            dumpIndex       <= w_dump_index_nxt;
            dumpValid       <= w_dump_valid_nxt;
            busy            <= w_busy_nxt;
            done            <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_dump_fill.sv
// Purpose : self-checking bench for regfile_dump_fill with a behavioural register file.
// Latency : inputs driven and outputs sampled on the falling edge, away from the active edge.
// Backpr. : bench drives dumpReady, optionally stalling the first beat of a dump.
module tb_regfile_dump_fill;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic          mode      = 1'b0;
    logic [AW-1:0] firstReg  = '0;
    logic [AW-1:0] lastReg   = '0;
    logic [DW-1:0] fillValue = '0;
    logic          dumpReady = 1'b0;
    logic [DW-1:0] outvalue;
    logic [AW-1:0] inr;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic          controlRegWrite;
    logic [DW-1:0] dumpData;
    logic [AW-1:0] dumpIndex;
    logic          dumpValid;
    logic          busy;
    logic          done;

    // Behavioural register file: DUT write port, plus a bench-side port for preloading.
    logic [DW-1:0] mem [32];
    logic          tb_we   = 1'b0;
    logic [AW-1:0] tb_widx = '0;
    logic [DW-1:0] tb_wdat = '0;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (controlRegWrite) mem[writeReg] <= writeData;
        else if (tb_we)      mem[tb_widx]  <= tb_wdat;
    end

    assign outvalue = mem[inr];

    regfile_dump_fill #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .firstReg       (firstReg),
        .lastReg        (lastReg),
        .fillValue      (fillValue),
        .outvalue       (outvalue),
        .inr            (inr),
        .writeReg       (writeReg),
        .writeData      (writeData),
        .controlRegWrite(controlRegWrite),
        .dumpData       (dumpData),
        .dumpIndex      (dumpIndex),
        .dumpValid      (dumpValid),
        .dumpReady      (dumpReady),
        .busy           (busy),
        .done           (done)
    );

    task automatic write_reg(input logic [AW-1:0] idx, input logic [DW-1:0] dat);
        tb_we = 1'b1; tb_widx = idx; tb_wdat = dat;
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    task automatic init_mem;
        for (int i = 0; i < 32; i++) write_reg(AW'(i), DW'(16'h1000 + i));
    endtask

    task automatic test_reset;
        logic [72:0] outs;
        reset = 1'b1;
        @(negedge clock);
        outs = {inr, writeReg, writeData, controlRegWrite, dumpData, dumpIndex, dumpValid, busy, done};
        checks++;
        if (outs !== '0) $display("FAIL reset_outputs got %h want 0", outs);
        else passed++;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle busy=%b done=%b want 0 0", busy, done);
        else passed++;
    endtask

    task automatic do_fill(input logic [AW-1:0] f, input logic [AW-1:0] l,
                           input logic [DW-1:0] v, input bit glitch);
        logic [AW-1:0] wq[$];
        logic [AW-1:0] e;
        int  n, busy_cyc, done_cnt, done_cyc;
        bit  finished, mem_ok;
        n = int'(l) - int'(f) + 1;
        for (int i = int'(f); i <= int'(l); i++) wq.push_back(AW'(i));
        busy_cyc = 0; done_cnt = 0; done_cyc = -1; finished = 0;
        mode = 1'b1; firstReg = f; lastReg = l; fillValue = v; start = 1'b1;
        for (int cyc = 1; cyc <= n + 8; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (glitch && cyc == 2) begin
                start = 1'b1; mode = 1'b1; firstReg = '0; lastReg = '1; fillValue = ~v;
            end
            if (controlRegWrite) begin
                checks++;
                if (wq.size() == 0) begin
                    $display("FAIL fill_extra_write got idx %0d want none", writeReg);
                end else begin
                    e = wq.pop_front();
                    if (writeReg !== e || writeData !== v)
                        $display("FAIL fill_write got idx %0d data %h want idx %0d data %h", writeReg, writeData, e, v);
                    else passed++;
                end
            end
            if (busy) busy_cyc++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (!busy) begin finished = 1; break; end
        end
        checks++;
        if (!finished) $display("FAIL fill_timeout busy still %b want 0", busy);
        else passed++;
        checks++;
        if (wq.size() != 0) $display("FAIL fill_missing got %0d writes outstanding want 0", wq.size());
        else passed++;
        checks++;
        if (busy_cyc != n + 1) $display("FAIL fill_busy_cycles got %0d want %0d", busy_cyc, n + 1);
        else passed++;
        checks++;
        if (done_cnt != 1 || done_cyc != n + 1)
            $display("FAIL fill_done got %0d pulses at cycle %0d want 1 at %0d", done_cnt, done_cyc, n + 1);
        else passed++;
        checks++;
        if (writeReg !== l || writeData !== v || controlRegWrite !== 1'b0)
            $display("FAIL fill_hold got idx %0d data %h we %b want %0d %h 0", writeReg, writeData, controlRegWrite, l, v);
        else passed++;
        mem_ok = 1;
        for (int i = int'(f); i <= int'(l); i++) if (mem[i] !== v) mem_ok = 0;
        checks++;
        if (!mem_ok) $display("FAIL fill_readback got mismatch in %0d..%0d want %h", f, l, v);
        else passed++;
    endtask

    task automatic do_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int stall_cyc);
        logic [AW+DW-1:0] bq[$];
        logic [AW+DW-1:0] e, held;
        int  n, busy_cyc, done_cnt, first_vld, last_acc, beats, stall_left;
        bit  finished, gap_ok, hold_ok;
        n = int'(l) - int'(f) + 1;
        for (int i = int'(f); i <= int'(l); i++) bq.push_back({AW'(i), mem[i]});
        busy_cyc = 0; done_cnt = 0; first_vld = -1; last_acc = -1; beats = 0;
        stall_left = stall_cyc; finished = 0; gap_ok = 1; hold_ok = 1; held = '0;
        mode = 1'b0; firstReg = f; lastReg = l; dumpReady = 1'b1; start = 1'b1;
        for (int cyc = 1; cyc <= 2 * n + stall_cyc + 10; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (dumpValid) begin
                if (first_vld < 0) begin
                    first_vld = cyc;
                    held = {dumpIndex, dumpData};
                end else if (beats == 0 && {dumpIndex, dumpData} !== held) begin
                    hold_ok = 0;
                end
                if (stall_left > 0) begin
                    dumpReady = 1'b0;
                    stall_left--;
                end else begin
                    dumpReady = 1'b1;
                    checks++;
                    if (bq.size() == 0) begin
                        $display("FAIL dump_extra_beat got idx %0d want none", dumpIndex);
                    end else begin
                        e = bq.pop_front();
                        if ({dumpIndex, dumpData} !== e)
                            $display("FAIL dump_beat got idx %0d data %h want idx %0d data %h",
                                     dumpIndex, dumpData, e[AW+DW-1:DW], e[DW-1:0]);
                        else passed++;
                    end
                    if (last_acc >= 0 && cyc - last_acc != 2) gap_ok = 0;
                    last_acc = cyc;
                    beats++;
                end
            end else begin
                if (first_vld > 0 && beats == 0) hold_ok = 0;
                dumpReady = 1'b1;
            end
            if (!busy) begin finished = 1; break; end
        end
        checks++;
        if (!finished) $display("FAIL dump_timeout busy still %b want 0", busy);
        else passed++;
        checks++;
        if (beats != n || bq.size() != 0) $display("FAIL dump_count got %0d beats want %0d", beats, n);
        else passed++;
        checks++;
        if (first_vld != 2) $display("FAIL dump_first_valid got cycle %0d want 2", first_vld);
        else passed++;
        checks++;
        if (!gap_ok) $display("FAIL dump_throughput got gap other than 2 want 2");
        else passed++;
        if (stall_cyc > 0) begin
            checks++;
            if (!hold_ok) $display("FAIL dump_stall_hold got beat changed during stall want held");
            else passed++;
        end
        checks++;
        if (busy_cyc != 2 * n + 1 + stall_cyc)
            $display("FAIL dump_busy_cycles got %0d want %0d", busy_cyc, 2 * n + 1 + stall_cyc);
        else passed++;
        checks++;
        if (done_cnt != 1 || dumpValid !== 1'b0)
            $display("FAIL dump_done got %0d pulses valid %b want 1 0", done_cnt, dumpValid);
        else passed++;
    endtask

    task automatic test_fill;
        do_fill(5'd5, 5'd7, 16'h00AA, 1'b0);
    endtask

    task automatic test_dump;
        write_reg(5'd5, 16'd16);
        write_reg(5'd11, 16'd24);
        do_dump(5'd5, 5'd11, 0);
    endtask

    task automatic test_dump_stall;
        do_dump(5'd5, 5'd6, 3);
    endtask

    task automatic test_full_range;
        do_fill(5'd0, 5'd31, 16'h5A5A, 1'b0);
        do_dump(5'd0, 5'd31, 0);
    endtask

    task automatic test_empty;
        int wr, vld, bz, dn, bz1;
        for (int m = 0; m < 2; m++) begin
            wr = 0; vld = 0; bz = 0; dn = 0; bz1 = 0;
            mode = m[0]; firstReg = 5'd9; lastReg = 5'd3; start = 1'b1;
            for (int cyc = 1; cyc <= 6; cyc++) begin
                @(negedge clock);
                start = 1'b0;
                if (controlRegWrite) wr++;
                if (dumpValid) vld++;
                if (busy) begin bz++; if (cyc == 1) bz1 = 1; end
                if (done) dn++;
            end
            checks++;
            if (wr != 0 || vld != 0) $display("FAIL empty_transfers mode %0d got we %0d valid %0d want 0 0", m, wr, vld);
            else passed++;
            checks++;
            if (bz != 1 || dn != 1 || bz1 != 1)
                $display("FAIL empty_status mode %0d got busy %0d done %0d busy_c1 %0d want 1 1 1", m, bz, dn, bz1);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 0;
        mode = 1'b1; firstReg = 5'd5; lastReg = 5'd10; fillValue = 16'h0BEE; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (controlRegWrite && writeReg == 5'd6) begin seen = 1; break; end
        end
        checks++;
        if (!seen) $display("FAIL reset_mid_reach got no write to 6 want write to 6");
        else passed++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (controlRegWrite !== 1'b0 || busy !== 1'b0 || writeReg !== '0)
            $display("FAIL reset_mid_drop got we %b busy %b idx %0d want 0 0 0", controlRegWrite, busy, writeReg);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (mem[5] !== 16'h0BEE || mem[6] !== 16'h5A5A)
            $display("FAIL reset_mid_mem got r5 %h r6 %h want 0bee 5a5a", mem[5], mem[6]);
        else passed++;
        // A start pulse mid-command must not disturb the running fill.
        do_fill(5'd12, 5'd15, 16'h1111, 1'b1);
        do_fill(5'd2, 5'd2, 16'h2222, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        init_mem();
        test_fill();
        test_dump();
        test_dump_stall();
        test_full_range();
        test_empty();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
